vga_render: RTL and testbench

VGA_RENDER -- requirements
Module: vga_render

---
 rtl/vga_pkg.sv | 26 ++
 rtl/vga_if.sv | 24 ++
 rtl/vga_timing.sv | 53 +++++
 rtl/vga_render.sv | 81 ++++++++
 tb/tb_vga_render.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, object category codes and the 12-bit palette.
package vga_pkg;

    localparam logic [9:0] H_VISIBLE_DEF = 10'd640;
    localparam logic [9:0] H_FRONT_DEF   = 10'd16;
    localparam logic [9:0] H_SYNC_DEF    = 10'd96;
    localparam logic [9:0] H_BACK_DEF    = 10'd48;
    localparam logic [9:0] V_VISIBLE_DEF = 10'd480;
    localparam logic [9:0] V_FRONT_DEF   = 10'd10;
    localparam logic [9:0] V_SYNC_DEF    = 10'd2;
    localparam logic [9:0] V_BACK_DEF    = 10'd33;

    typedef enum logic [3:0] {
        NONE   = 4'd0,
        WALL   = 4'd1,
        TANK   = 4'd2,
        BULLET = 4'd3
    } category_t;

    localparam logic [11:0] COL_NONE   = 12'h000;
    localparam logic [11:0] COL_WALL   = 12'h888;
    localparam logic [11:0] COL_TANK   = 12'h0F0;
    localparam logic [11:0] COL_BULLET = 12'hF00;
    localparam logic [11:0] COL_OTHER  = 12'hF0F;

endpackage

// File: rtl/vga_if.sv
// Pixel bus between the renderer (master) and the game loop / display side (slave).
interface vga_if;

    logic [3:0] category;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       hsync;
    logic       vsync;
    logic [3:0] vga_r;
    logic [3:0] vga_g;
    logic [3:0] vga_b;
    logic       frame_start;

    modport master (
        input  category,
        output pixel_x, pixel_y, hsync, vsync, vga_r, vga_g, vga_b, frame_start
    );

    modport slave (
        output category,
        input  pixel_x, pixel_y, hsync, vsync, vga_r, vga_g, vga_b, frame_start
    );

endinterface

// File: rtl/vga_timing.sv
// Pixel phase, h/v raster counters and combinational sync / video_on decode.
module vga_timing import vga_pkg::*; #(
    parameter logic [9:0] H_VISIBLE = H_VISIBLE_DEF,
    parameter logic [9:0] H_FRONT   = H_FRONT_DEF,
    parameter logic [9:0] H_SYNC    = H_SYNC_DEF,
    parameter logic [9:0] H_BACK    = H_BACK_DEF,
    parameter logic [9:0] V_VISIBLE = V_VISIBLE_DEF,
    parameter logic [9:0] V_FRONT   = V_FRONT_DEF,
    parameter logic [9:0] V_SYNC    = V_SYNC_DEF,
    parameter logic [9:0] V_BACK    = V_BACK_DEF
) (
    input  logic       clk_100mhz,
    input  logic       rst,
    output logic [1:0] ph,
    output logic [9:0] h,
    output logic [9:0] v,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on
);

    localparam logic [9:0] H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam logic [9:0] V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam logic [9:0] H_SYNC_START = H_VISIBLE + H_FRONT;
    localparam logic [9:0] H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam logic [9:0] V_SYNC_START = V_VISIBLE + V_FRONT;
    localparam logic [9:0] V_SYNC_END   = V_SYNC_START + V_SYNC;

    // Four clocks per pixel; counters step on the last phase so new
    // coordinates land together with ph==0.
    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            ph <= 2'd0;
            h  <= 10'd0;
            v  <= 10'd0;
        end else begin
            ph <= ph + 2'd1;
            if (ph == 2'd3) begin
                if (h == H_TOTAL - 10'd1) begin
                    h <= 10'd0;
                    v <= (v == V_TOTAL - 10'd1) ? 10'd0 : v + 10'd1;
                end else begin
                    h <= h + 10'd1;
                end
            end
        end
    end

    assign hsync    = !((h >= H_SYNC_START) && (h < H_SYNC_END));
    assign vsync    = !((v >= V_SYNC_START) && (v < V_SYNC_END));
    assign video_on = (h < H_VISIBLE) && (v < V_VISIBLE);

endmodule

// File: rtl/vga_render.sv
// VGA renderer: raster timing plus category-to-colour mapping aligned two clocks behind the coordinates.
module vga_render import vga_pkg::*; #(
    parameter logic [9:0] H_VISIBLE = H_VISIBLE_DEF,
    parameter logic [9:0] H_FRONT   = H_FRONT_DEF,
    parameter logic [9:0] H_SYNC    = H_SYNC_DEF,
    parameter logic [9:0] H_BACK    = H_BACK_DEF,
    parameter logic [9:0] V_VISIBLE = V_VISIBLE_DEF,
    parameter logic [9:0] V_FRONT   = V_FRONT_DEF,
    parameter logic [9:0] V_SYNC    = V_SYNC_DEF,
    parameter logic [9:0] V_BACK    = V_BACK_DEF
) (
    input  logic   clk_100mhz,
    input  logic   rst,
    vga_if.master  vga
);

    logic [1:0]  ph;
    logic [9:0]  h;
    logic [9:0]  v;
    logic        hsync_p0;
    logic        vsync_p0;
    logic        video_on_p0;
    logic [11:0] rgb_p1;
    logic        hsync_p1;
    logic        vsync_p1;

    function automatic logic [11:0] cat_colour(input logic [3:0] cat);
        case (cat)
            NONE:    return COL_NONE;
            WALL:    return COL_WALL;
            TANK:    return COL_TANK;
            BULLET:  return COL_BULLET;
            default: return COL_OTHER;
        endcase
    endfunction

    vga_timing #(
        .H_VISIBLE (H_VISIBLE),
        .H_FRONT   (H_FRONT),
        .H_SYNC    (H_SYNC),
        .H_BACK    (H_BACK),
        .V_VISIBLE (V_VISIBLE),
        .V_FRONT   (V_FRONT),
        .V_SYNC    (V_SYNC),
        .V_BACK    (V_BACK)
    ) u_timing (
        .clk_100mhz (clk_100mhz),
        .rst        (rst),
        .ph         (ph),
        .h          (h),
        .v          (v),
        .hsync      (hsync_p0),
        .vsync      (vsync_p0),
        .video_on   (video_on_p0)
    );

    // p0 -> p1: capture on the edge that opens ph==2, one clock after the
    // game loop's registered category settles for these coordinates.
    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            rgb_p1   <= COL_NONE;
            hsync_p1 <= 1'b1;
            vsync_p1 <= 1'b1;
        end else if (ph == 2'd1) begin
            rgb_p1   <= video_on_p0 ? cat_colour(vga.category) : COL_NONE;
            hsync_p1 <= hsync_p0;
            vsync_p1 <= vsync_p0;
        end
    end

    assign vga.pixel_x     = h;
    assign vga.pixel_y     = v;
    assign vga.hsync       = hsync_p1;
    assign vga.vsync       = vsync_p1;
    assign vga.vga_r       = rgb_p1[11:8];
    assign vga.vga_g       = rgb_p1[7:4];
    assign vga.vga_b       = rgb_p1[3:0];
    // Gated by rst so the pulse lands in the first clock after release.
    assign vga.frame_start = (ph == 2'd0) && (h == 10'd0) && (v == 10'd0) && !rst;

endmodule

// File: tb/tb_vga_render.sv
// Bench for vga_render: a shrunk-raster instance and a default 640x480 instance checked against a time-index model.
module tb_vga_render;

    localparam int M_SPOT = 0;
    localparam int M_C3   = 1;
    localparam int M_C9   = 2;
    localparam int M_RAND = 3;

    logic clk_100mhz = 1'b0;
    logic rst = 1'b1;
    int   mode = M_SPOT;
    logic [3:0] lut [64];

    int n = 0;
    bit model_on = 0;
    logic [3:0] samp_s = 4'd0;
    logic [3:0] samp_d = 4'd0;

    int n_checks = 0;
    int n_fail = 0;

    int spot_cnt_s = 0, spot_first_s = -1, spot_cnt_d = 0, spot_first_d = -1;
    int fs_cnt_s = 0, fs_cnt_d = 0;
    int hs_fall_d = -1, vs_fall_s = -1;
    logic prev_hs_d = 1'b1, prev_vs_s = 1'b1;

    vga_if if_s ();
    vga_if if_d ();

    vga_render #(
        .H_VISIBLE (10'd20), .H_FRONT (10'd3), .H_SYNC (10'd5), .H_BACK (10'd4),
        .V_VISIBLE (10'd12), .V_FRONT (10'd2), .V_SYNC (10'd2), .V_BACK (10'd3)
    ) dut_s (
        .clk_100mhz (clk_100mhz),
        .rst        (rst),
        .vga        (if_s)
    );

    vga_render dut_d (
        .clk_100mhz (clk_100mhz),
        .rst        (rst),
        .vga        (if_d)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (n=%0d)", nm, act, exp, n);
        end
    endtask

    function automatic logic [11:0] exp_colour(input logic [3:0] c);
        case (c)
            4'd0:    return 12'h000;
            4'd1:    return 12'h888;
            4'd2:    return 12'h0F0;
            4'd3:    return 12'hF00;
            default: return 12'hF0F;
        endcase
    endfunction

    function automatic logic [3:0] cat_of(input int md, input int x, input int y,
                                          input int sx, input int sy);
        case (md)
            M_SPOT:  return (x == sx && y == sy) ? 4'd2 : 4'd0;
            M_C3:    return 4'd3;
            M_C9:    return 4'd9;
            default: return lut[(x + 7 * y) % 64];
        endcase
    endfunction

    // Expected outputs at clock index n since the last reset edge, from raster arithmetic.
    task automatic check_dut(input string nm, input int ht, input int vt, input int hv,
                             input int hs0, input int hs1, input int vv, input int vs0,
                             input int vs1, input logic [3:0] cat, input logic [9:0] px,
                             input logic [9:0] py, input logic hs, input logic vs,
                             input logic [11:0] rgb, input logic fs);
        int pix, q, qx, qy;
        int ehs, evs, ergb, efs;
        pix  = n / 4;
        ehs  = 1;
        evs  = 1;
        ergb = 0;
        if (n >= 2) begin
            q    = (n - 2) / 4;
            qx   = q % ht;
            qy   = (q / ht) % vt;
            ehs  = (qx >= hs0 && qx < hs1) ? 0 : 1;
            evs  = (qy >= vs0 && qy < vs1) ? 0 : 1;
            ergb = (qx < hv && qy < vv) ? int'(exp_colour(cat)) : 0;
        end
        efs = (!rst && (n % (4 * ht * vt)) == 0) ? 1 : 0;
        chk({nm, "_pixel_x"}, int'(px), pix % ht);
        chk({nm, "_pixel_y"}, int'(py), (pix / ht) % vt);
        chk({nm, "_hsync"}, int'(hs), ehs);
        chk({nm, "_vsync"}, int'(vs), evs);
        chk({nm, "_rgb"}, int'(rgb), ergb);
        chk({nm, "_frame_start"}, int'(fs), efs);
    endtask

    // Model time base and the category value present during each pixel's second clock.
    always @(posedge clk_100mhz) begin
        if (rst) begin
            n <= 0;
            model_on <= 1'b1;
        end else begin
            if (n % 4 == 1) begin
                samp_s <= if_s.category;
                samp_d <= if_d.category;
            end
            n <= n + 1;
        end
    end

    always @(negedge clk_100mhz) begin
        if (model_on) begin
            check_dut("s", 32, 19, 20, 23, 28, 12, 14, 16, samp_s, if_s.pixel_x, if_s.pixel_y,
                      if_s.hsync, if_s.vsync, {if_s.vga_r, if_s.vga_g, if_s.vga_b},
                      if_s.frame_start);
            check_dut("d", 800, 525, 640, 656, 752, 480, 490, 492, samp_d, if_d.pixel_x,
                      if_d.pixel_y, if_d.hsync, if_d.vsync, {if_d.vga_r, if_d.vga_g, if_d.vga_b},
                      if_d.frame_start);
            if (mode == M_SPOT) begin
                if ({if_s.vga_r, if_s.vga_g, if_s.vga_b} == 12'h0F0) begin
                    if (spot_cnt_s == 0) spot_first_s = n;
                    spot_cnt_s++;
                end
                if ({if_d.vga_r, if_d.vga_g, if_d.vga_b} == 12'h0F0) begin
                    if (spot_cnt_d == 0) spot_first_d = n;
                    spot_cnt_d++;
                end
                if (if_s.frame_start) fs_cnt_s++;
                if (if_d.frame_start) fs_cnt_d++;
            end
            if (n == 0) begin
                hs_fall_d = -1;
                vs_fall_s = -1;
            end
            if (prev_hs_d && !if_d.hsync) begin
                chk("hsync_d_start", n % 3200, 2626);
                if (hs_fall_d >= 0) chk("hsync_d_period", n - hs_fall_d, 3200);
                hs_fall_d = n;
            end
            if (!prev_hs_d && if_d.hsync && hs_fall_d >= 0)
                chk("hsync_d_width", n - hs_fall_d, 384);
            if (prev_vs_s && !if_s.vsync) begin
                chk("vsync_s_start", n % 2432, 1794);
                if (vs_fall_s >= 0) chk("vsync_s_period", n - vs_fall_s, 2432);
                vs_fall_s = n;
            end
            if (!prev_vs_s && if_s.vsync && vs_fall_s >= 0)
                chk("vsync_s_width", n - vs_fall_s, 256);
            prev_hs_d = if_d.hsync;
            prev_vs_s = if_s.vsync;
        end
    end

    // Game-loop stand-in: category registered one clock after the coordinates it describes.
    initial begin
        int pxs = 0, pys = 0, pxd = 0, pyd = 0;
        if_s.category = 4'd0;
        if_d.category = 4'd0;
        forever begin
            @(posedge clk_100mhz);
            #1;
            if_s.category = cat_of(mode, pxs, pys, 5, 3);
            if_d.category = cat_of(mode, pxd, pyd, 100, 1);
            pxs = int'(if_s.pixel_x);
            pys = int'(if_s.pixel_y);
            pxd = int'(if_d.pixel_x);
            pyd = int'(if_d.pixel_y);
        end
    end

    task automatic wait_n(input int target);
        for (int i = 0; i < 60000 && n < target; i++) @(negedge clk_100mhz);
        if (n < target) chk("wait_timeout", n, target);
    endtask

    initial begin
        bit found;
        for (int i = 0; i < 64; i++) lut[i] = 4'($urandom_range(0, 15));
        mode = M_SPOT;
        rst  = 1'b1;
        repeat (3) @(posedge clk_100mhz);
        #1 rst = 1'b0;
        @(negedge clk_100mhz);
        chk("release_fs_s", int'(if_s.frame_start), 1);
        chk("release_fs_d", int'(if_d.frame_start), 1);
        chk("release_px_s", int'(if_s.pixel_x), 0);
        chk("release_hs_d", int'(if_d.hsync), 1);

        wait_n(7400);
        chk("spot_s_count", spot_cnt_s, 12);
        chk("spot_s_first", spot_first_s, 406);
        chk("spot_d_count", spot_cnt_d, 4);
        chk("spot_d_first", spot_first_d, 3602);
        chk("fs_s_count", fs_cnt_s, 4);
        chk("fs_d_count", fs_cnt_d, 1);

        mode = M_C3;
        wait_n(7400 + 4864);
        mode = M_C9;
        wait_n(7400 + 4864 + 2432);
        mode = M_RAND;
        wait_n(7400 + 4864 + 2432 + 2432);

        found = 0;
        for (int i = 0; i < 5000 && !found; i++) begin
            @(negedge clk_100mhz);
            if (if_s.pixel_x == 10'd25 && if_s.pixel_y == 10'd15) found = 1;
        end
        chk("rst_point_found", int'(found), 1);
        if (found) begin
            chk("pre_rst_vsync", int'(if_s.vsync), 0);
            chk("pre_rst_hsync", int'(if_s.hsync), 0);
            @(posedge clk_100mhz);
            #1 rst = 1'b1;
            @(posedge clk_100mhz);
            #1 rst = 1'b0;
            @(negedge clk_100mhz);
            chk("post_rst_vsync", int'(if_s.vsync), 1);
            chk("post_rst_hsync", int'(if_s.hsync), 1);
            chk("post_rst_rgb", int'({if_s.vga_r, if_s.vga_g, if_s.vga_b}), 0);
            chk("post_rst_px", int'(if_s.pixel_x), 0);
            chk("post_rst_py", int'(if_s.pixel_y), 0);
            chk("post_rst_fs", int'(if_s.frame_start), 1);
        end

        repeat (3000) @(negedge clk_100mhz);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
